// File: rtl/mcu_rst_pkg.sv
// Shared types and constants for the MCU reset sequencer: FSM encoding, reset-cause bit
// positions and a counter-width helper.
package mcu_rst_pkg;

  typedef enum logic [1:0] {
    StLock = 2'd0,
    StHold = 2'd1,
    StRun  = 2'd2
  } rst_state_e;

  localparam int unsigned NumCauses   = 5;
  localparam int unsigned CauseLock   = 0;
  localparam int unsigned CauseBtn    = 1;
  localparam int unsigned CauseSys    = 2;
  localparam int unsigned CauseLockup = 3;
  localparam int unsigned CauseWdog   = 4;

  localparam logic [NumCauses-1:0] CausePor = 5'b00001;

  // Width of a counter that runs 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rst_debounce.sv
// Pushbutton conditioner: 2-flop synchronizer followed by a press/release debouncer that
// emits one btn_evt pulse per qualified press.
module rst_debounce
  import mcu_rst_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 65536
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_n_i,
  output logic btn_evt
);

  localparam int unsigned CntW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  logic            btn_meta_q, btn_sync_q;
  logic            armed_q, armed_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            evt;

  // armed_q=1: counting low samples toward a press; armed_q=0: counting high samples to re-arm.
  always_comb begin
    armed_d = armed_q;
    cnt_d   = cnt_q + CntW'(1);
    evt     = 1'b0;
    if (armed_q) begin
      if (btn_sync_q) begin
        cnt_d = '0;
      end else if (cnt_q == CntMax) begin
        evt     = 1'b1;
        armed_d = 1'b0;
        cnt_d   = '0;
      end
    end else begin
      if (!btn_sync_q) begin
        cnt_d = '0;
      end else if (cnt_q == CntMax) begin
        armed_d = 1'b1;
        cnt_d   = '0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      btn_meta_q <= 1'b1;
      btn_sync_q <= 1'b1;
      armed_q    <= 1'b1;
      cnt_q      <= '0;
    end else begin
      btn_meta_q <= btn_n_i;
      btn_sync_q <= btn_meta_q;
      armed_q    <= armed_d;
      cnt_q      <= cnt_d;
    end
  end

  assign btn_evt = evt;

endmodule

// File: rtl/mcu_rst_seq.sv
// MCU reset sequencer: waits for a stable PLL lock, holds NRST for a fixed time, then runs;
// run-time reset requests re-enter the hold phase and are logged in rst_cause/rst_count.
module mcu_rst_seq
  import mcu_rst_pkg::*;
#(
  parameter int unsigned LOCK_STABLE     = 1024,
  parameter int unsigned HOLD_CYCLES     = 256,
  parameter int unsigned DEBOUNCE_CYCLES = 65536,
  parameter bit          LOCKUP_RST_EN   = 1'b1
) (
  input  logic                 fpga_clk_in,
  input  logic                 fpga_rst_in,
  input  logic                 pll_locked,
  input  logic                 btn_rst_n,
  input  logic                 sys_reset_req,
  input  logic                 lockup,
  input  logic                 wdog_reset_req,
  output logic                 mcu_nrst,
  output logic                 run,
  output logic [NumCauses-1:0] rst_cause,
  output logic [7:0]           rst_count
);

  localparam int unsigned LockW = cnt_width(LOCK_STABLE);
  localparam int unsigned HoldW = cnt_width(HOLD_CYCLES);
  localparam logic [LockW-1:0] LockMax = LockW'(LOCK_STABLE - 1);
  localparam logic [HoldW-1:0] HoldMax = HoldW'(HOLD_CYCLES - 1);

  logic                 lock_meta_q, lock_sync_q;
  logic                 btn_evt;
  rst_state_e           state_q, state_d;
  logic [LockW-1:0]     lock_cnt_q, lock_cnt_d;
  logic [HoldW-1:0]     hold_cnt_q, hold_cnt_d;
  logic                 nrst_q, nrst_d;
  logic [NumCauses-1:0] cause_q, cause_d;
  logic [7:0]           count_q, count_d;
  logic [NumCauses-1:0] req_vec;

  rst_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk_i  (fpga_clk_in),
    .rst_ni (fpga_rst_in),
    .btn_n_i(btn_rst_n),
    .btn_evt(btn_evt)
  );

  always_comb begin
    req_vec              = '0;
    req_vec[CauseBtn]    = btn_evt;
    req_vec[CauseSys]    = sys_reset_req;
    req_vec[CauseLockup] = lockup & LOCKUP_RST_EN;
    req_vec[CauseWdog]   = wdog_reset_req;
  end

  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    hold_cnt_d = hold_cnt_q;
    cause_d    = cause_q;
    count_d    = count_q;
    unique case (state_q)
      StLock: begin
        if (!lock_sync_q) begin
          lock_cnt_d = '0;
        end else if (lock_cnt_q == LockMax) begin
          state_d    = StHold;
          lock_cnt_d = '0;
          hold_cnt_d = '0;
        end else begin
          lock_cnt_d = lock_cnt_q + LockW'(1);
        end
      end
      // Requests are deliberately not looked at here, so they cannot extend the hold.
      StHold: begin
        if (!lock_sync_q) begin
          state_d    = StLock;
          lock_cnt_d = '0;
        end else if (hold_cnt_q == HoldMax) begin
          state_d    = StRun;
          hold_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + HoldW'(1);
        end
      end
      StRun: begin
        if (!lock_sync_q) begin
          state_d    = StLock;
          lock_cnt_d = '0;
          cause_d    = CausePor;
          count_d    = (count_q == 8'hff) ? count_q : count_q + 8'd1;
        end else if (|req_vec) begin
          state_d    = StHold;
          hold_cnt_d = '0;
          cause_d    = req_vec;
          count_d    = (count_q == 8'hff) ? count_q : count_q + 8'd1;
        end
      end
      default: begin
        state_d    = StLock;
        lock_cnt_d = '0;
        hold_cnt_d = '0;
      end
    endcase
    nrst_d = (state_d == StRun);
  end

  always_ff @(posedge fpga_clk_in or negedge fpga_rst_in) begin
    if (!fpga_rst_in) begin
      lock_meta_q <= 1'b0;
      lock_sync_q <= 1'b0;
      state_q     <= StLock;
      lock_cnt_q  <= '0;
      hold_cnt_q  <= '0;
      nrst_q      <= 1'b0;
      cause_q     <= CausePor;
      count_q     <= '0;
    end else begin
      lock_meta_q <= pll_locked;
      lock_sync_q <= lock_meta_q;
      state_q     <= state_d;
      lock_cnt_q  <= lock_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      nrst_q      <= nrst_d;
      cause_q     <= cause_d;
      count_q     <= count_d;
    end
  end

  assign mcu_nrst  = nrst_q;
  assign run       = (state_q == StRun);
  assign rst_cause = cause_q;
  assign rst_count = count_q;

endmodule

// File: tb/tb_mcu_rst_seq.sv
// Directed bench for mcu_rst_seq with LOCK_STABLE=16, HOLD_CYCLES=32, DEBOUNCE_CYCLES=8.
// dut_en has lockup resets enabled, dut_dis has them disabled; both share all inputs.
module tb_mcu_rst_seq;

  logic       clk = 1'b0;
  logic       rst_n, pll, btn_n, sys_req, lk, wd_req;
  logic       nrst1, run1, nrst0, run0;
  logic [4:0] cause1, cause0;
  logic [7:0] count1, count0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mcu_rst_seq #(
    .LOCK_STABLE(16), .HOLD_CYCLES(32), .DEBOUNCE_CYCLES(8), .LOCKUP_RST_EN(1'b1)
  ) dut_en (
    .fpga_clk_in(clk), .fpga_rst_in(rst_n), .pll_locked(pll), .btn_rst_n(btn_n),
    .sys_reset_req(sys_req), .lockup(lk), .wdog_reset_req(wd_req),
    .mcu_nrst(nrst1), .run(run1), .rst_cause(cause1), .rst_count(count1)
  );

  mcu_rst_seq #(
    .LOCK_STABLE(16), .HOLD_CYCLES(32), .DEBOUNCE_CYCLES(8), .LOCKUP_RST_EN(1'b0)
  ) dut_dis (
    .fpga_clk_in(clk), .fpga_rst_in(rst_n), .pll_locked(pll), .btn_rst_n(btn_n),
    .sys_reset_req(sys_req), .lockup(lk), .wdog_reset_req(wd_req),
    .mcu_nrst(nrst0), .run(run0), .rst_cause(cause0), .rst_count(count0)
  );

  typedef struct {
    logic       sys;
    logic       lk;
    logic       wd;
    logic [4:0] cause_en;
    logic [4:0] cause_dis;
    bit         rst_dis;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Edges from now until dut_en releases NRST, counting the first edge.
  task automatic cycles_to_run(output int n, output bit ok);
    n  = 0;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      step();
      n++;
      if (nrst1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Counts dut_en low samples from now until both DUTs are running again.
  task automatic run_until_up(output int lows, output bit seen0, output bit ok);
    lows  = 0;
    seen0 = 1'b0;
    ok    = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (!nrst1) lows++;
      if (!nrst0) seen0 = 1'b1;
      if (lows > 0 && nrst1 && nrst0) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int         n, lows;
    bit         ok, seen0, all_ok;
    int         exp_cnt1, exp_cnt0;
    logic [4:0] exp_cause0;

    vecs[0] = '{1'b1, 1'b0, 1'b0, 5'b00100, 5'b00100, 1'b1};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 5'b01000, 5'b00100, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 5'b10000, 5'b10000, 1'b1};
    vecs[3] = '{1'b1, 1'b0, 1'b1, 5'b10100, 5'b10100, 1'b1};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 5'b11100, 5'b10100, 1'b1};
    vecs[5] = '{1'b0, 1'b1, 1'b1, 5'b11000, 5'b10000, 1'b1};

    rst_n = 1'b0; pll = 1'b0; btn_n = 1'b1; sys_req = 1'b0; lk = 1'b0; wd_req = 1'b0;
    repeat (3) step();
    check("reset_nrst", {31'd0, nrst1}, 32'd0);
    check("reset_run", {31'd0, run1}, 32'd0);
    check("reset_run_dis", {31'd0, run0}, 32'd0);
    check("reset_cause", {27'd0, cause1}, 32'h01);
    check("reset_count", {24'd0, count1}, 32'd0);

    // Power-up: 2 sync + 16 lock + 32 hold edges.
    rst_n = 1'b1;
    repeat (10) step();
    pll = 1'b1;
    cycles_to_run(n, ok);
    check("powerup_ok", {31'd0, ok}, 32'd1);
    check("powerup_edges", n, 32'd50);
    check("powerup_run", {31'd0, run1}, 32'd1);
    check("powerup_nrst_dis", {31'd0, nrst0}, 32'd1);
    check("powerup_cause", {27'd0, cause1}, 32'h01);
    check("powerup_count", {24'd0, count1}, 32'd0);
    exp_cnt1 = 0;
    exp_cnt0 = 0;

    // Bouncing button then a solid press: one reset, 32 low cycles.
    for (int b = 0; b < 5; b++) begin
      btn_n = 1'b0;
      repeat (3) step();
      btn_n = 1'b1;
      repeat (3) step();
    end
    check("bounce_no_reset", {31'd0, nrst1}, 32'd1);
    btn_n = 1'b0;
    run_until_up(lows, seen0, ok);
    btn_n = 1'b1;
    exp_cnt1++;
    exp_cnt0++;
    check("btn_ok", {31'd0, ok}, 32'd1);
    check("btn_low_len", lows, 32'd32);
    check("btn_cause", {27'd0, cause1}, 32'h02);
    check("btn_count", {24'd0, count1}, exp_cnt1);
    repeat (20) step();
    check("btn_single_count", {24'd0, count1}, exp_cnt1);
    check("btn_single_nrst", {31'd0, nrst1}, 32'd1);
    exp_cause0 = 5'b00010;

    // One-cycle request combinations in RUN.
    for (int v = 0; v < 6; v++) begin
      sys_req = vecs[v].sys;
      lk      = vecs[v].lk;
      wd_req  = vecs[v].wd;
      step();
      sys_req = 1'b0;
      lk      = 1'b0;
      wd_req  = 1'b0;
      run_until_up(lows, seen0, ok);
      exp_cnt1++;
      if (vecs[v].rst_dis) begin
        exp_cnt0++;
        exp_cause0 = vecs[v].cause_dis;
      end
      check($sformatf("vec%0d_ok", v), {31'd0, ok}, 32'd1);
      check($sformatf("vec%0d_low_len", v), lows, 32'd32);
      check($sformatf("vec%0d_cause_en", v), {27'd0, cause1}, {27'd0, vecs[v].cause_en});
      check($sformatf("vec%0d_count_en", v), {24'd0, count1}, exp_cnt1);
      check($sformatf("vec%0d_rst_dis", v), {31'd0, seen0}, {31'd0, vecs[v].rst_dis});
      check($sformatf("vec%0d_cause_dis", v), {27'd0, cause0}, {27'd0, exp_cause0});
      check($sformatf("vec%0d_count_dis", v), {24'd0, count0}, exp_cnt0);
    end

    // sys+wdog together, sys held well into HOLD: still a single 32-cycle reset.
    sys_req = 1'b1;
    wd_req  = 1'b1;
    lows    = 0;
    ok      = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (i == 0) wd_req = 1'b0;
      if (i == 19) sys_req = 1'b0;
      if (!nrst1) lows++;
      if (lows > 0 && nrst1) begin
        ok = 1'b1;
        break;
      end
    end
    exp_cnt1++;
    check("held_ok", {31'd0, ok}, 32'd1);
    check("held_low_len", lows, 32'd32);
    check("held_cause", {27'd0, cause1}, 32'h14);
    check("held_count", {24'd0, count1}, exp_cnt1);

    // Lock loss coinciding with a watchdog request: lock wins.
    pll = 1'b0;
    step();
    step();
    wd_req = 1'b1;
    step();
    wd_req = 1'b0;
    exp_cnt1++;
    check("lockloss_nrst", {31'd0, nrst1}, 32'd0);
    check("lockloss_cause", {27'd0, cause1}, 32'h01);
    check("lockloss_count", {24'd0, count1}, exp_cnt1);
    repeat (3) step();
    sys_req = 1'b1;
    wd_req  = 1'b1;
    step();
    sys_req = 1'b0;
    wd_req  = 1'b0;
    step();
    check("lock_ignore_cause", {27'd0, cause1}, 32'h01);
    check("lock_ignore_count", {24'd0, count1}, exp_cnt1);

    // Relock with a one-cycle glitch once lock_cnt has reached 10.
    pll = 1'b1;
    n   = 0;
    repeat (10) begin
      step();
      n++;
    end
    pll = 1'b0;
    step();
    n++;
    pll = 1'b1;
    begin
      int rest;
      cycles_to_run(rest, ok);
      n += rest;
    end
    check("glitch_ok", {31'd0, ok}, 32'd1);
    check("glitch_edges", n, 32'd61);

    // Saturation.
    all_ok = 1'b1;
    for (int r = 0; r < 300; r++) begin
      wd_req = 1'b1;
      step();
      wd_req = 1'b0;
      run_until_up(lows, seen0, ok);
      if (!ok) all_ok = 1'b0;
    end
    check("sat_ok", {31'd0, all_ok}, 32'd1);
    check("sat_count_en", {24'd0, count1}, 32'd255);
    check("sat_count_dis", {24'd0, count0}, 32'd255);

    // Asynchronous reset in the middle of HOLD.
    wd_req = 1'b1;
    step();
    wd_req = 1'b0;
    repeat (5) step();
    check("hold_nrst", {31'd0, nrst1}, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_nrst", {31'd0, nrst1}, 32'd0);
    check("async_run", {31'd0, run1}, 32'd0);
    check("async_cause", {27'd0, cause1}, 32'h01);
    check("async_count", {24'd0, count1}, 32'd0);
    step();
    rst_n = 1'b1;
    cycles_to_run(n, ok);
    check("restart_ok", {31'd0, ok}, 32'd1);
    check("restart_edges", n, 32'd50);
    check("restart_count", {24'd0, count1}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mcu_rst_seq.md
MCU_RST_SEQ -- requirements
Module: mcu_rst_seq

Interface
REQ-001 Parameter LOCK_STABLE, default 1024: consecutive cycles pll_locked must be high before the hold phase starts.
REQ-002 Parameter HOLD_CYCLES, default 256: cycles NRST stays asserted after lock, or after any run-time reset request.
REQ-003 Parameter DEBOUNCE_CYCLES, default 65536: consecutive synchronized-low samples that qualify a button press.
REQ-004 Parameter LOCKUP_RST_EN, default 1: when 1, a core lockup triggers a reset.
REQ-005 fpga_clk_in  in  1  single clock, from the FPGA clock/reset block.
REQ-006 fpga_rst_in  in  1  reset; asynchronous, active-low.
REQ-007 pll_locked  in  1  clock-generator lock; asynchronous to fpga_clk_in.
REQ-008 btn_rst_n  in  1  raw pushbutton, active-low; asynchronous and bouncing.
REQ-009 sys_reset_req  in  1  core SYSRESETREQ, synchronous, level.
REQ-010 lockup  in  1  core LOCKUP, synchronous, level.
REQ-011 wdog_reset_req  in  1  watchdog reset request, synchronous, level.
REQ-012 mcu_nrst  out  1  registered active-low reset to the MCU NRST.
REQ-013 run  out  1  high only in state RUN.
REQ-014 rst_cause  out  5  sticky cause: bit0 lock/POR, bit1 button, bit2 sysreset, bit3 lockup, bit4 watchdog.
REQ-015 rst_count  out  8  count of RUN-to-reset transitions; saturates.

Function
REQ-016 pll_locked shall pass through a 2-flop synchronizer; btn_rst_n through a 2-flop synchronizer and then a debouncer.
REQ-017 btn_evt shall pulse for 1 cycle when the synchronized button has been low for DEBOUNCE_CYCLES consecutive cycles.
REQ-018 btn_evt shall re-arm only after the synchronized button has been high for DEBOUNCE_CYCLES consecutive cycles.
REQ-019 A high sample during the low count, or a low sample during the high count, shall restart that counter at 0.
REQ-020 The FSM shall have three states: LOCK, HOLD and RUN.
REQ-021 LOCK: mcu_nrst=0; lock_cnt increments while the synchronized lock is 1 and clears to 0 when it is 0; at lock_cnt==LOCK_STABLE-1 with lock still 1, go to HOLD.
REQ-022 HOLD: mcu_nrst=0; hold_cnt counts 0..HOLD_CYCLES-1, then the FSM goes to RUN; a loss of synchronized lock in HOLD goes to LOCK.
REQ-023 RUN: mcu_nrst=1. Loss of synchronized lock goes to LOCK; otherwise any request (btn_evt, sys_reset_req, wdog_reset_req, or lockup when LOCKUP_RST_EN=1) goes to HOLD.
REQ-024 Loss of lock shall take priority over all other requests.
REQ-025 mcu_nrst shall be a flop output that goes low the cycle after the leaving-RUN decision and high in the first RUN cycle.
REQ-026 On any exit from RUN, rst_cause shall be overwritten with all active sources that cycle; simultaneous sources all set.
REQ-027 On loss of lock, rst_cause shall be 5'b00001 only.
REQ-028 rst_cause shall hold its value in LOCK and HOLD.
REQ-029 Requests arriving in LOCK or HOLD shall be ignored; they shall neither restart hold_cnt nor change rst_cause.
REQ-030 rst_count shall increment on each RUN exit and saturate at 255.
REQ-031 Counter widths shall be $clog2 of the parameter, minimum 1 bit; the parameter range is 2..2^20.

Reset
REQ-032 fpga_rst_in low shall clear all state asynchronously: FSM=LOCK, mcu_nrst=0, run=0, rst_cause=5'b00001, rst_count=0, all counters 0.
REQ-033 Synchronizer flops shall reset to lock=0 and button=1 (not pressed).
REQ-034 Release of fpga_rst_in in mid-operation shall restart the sequence from LOCK; no state is retained.

Structure
REQ-035 Package mcu_rst_pkg shall hold the state encoding (LOCK=2'd0, HOLD=2'd1, RUN=2'd2) and the rst_cause bit-index constants.
REQ-036 The synchronizer and debouncer shall be one sub-module, rst_debounce, parameterised by DEBOUNCE_CYCLES, with output btn_evt.
REQ-037 The block shall sit between the FPGA clock/reset block and the MCU NRST.

Verification (LOCK_STABLE=16, HOLD_CYCLES=32, DEBOUNCE_CYCLES=8)
REQ-038 Power-up: lock rises at cycle 10 -> mcu_nrst rises about 16+32+sync cycles later; rst_cause=5'b00001; rst_count=0.
REQ-039 Lock glitch: lock low 1 cycle at lock_cnt=10, then high -> lock_cnt restarts; NRST release is delayed by a further 16 cycles.
REQ-040 Button: 5 bounces of 3 cycles low, then 8+ cycles low in RUN -> exactly one reset; 32-cycle NRST low; rst_cause=5'b00010; rst_count=1.
REQ-041 Simultaneous sys_reset_req and wdog_reset_req in RUN -> rst_cause=5'b10100; sys_reset_req held through HOLD -> only one reset.
REQ-042 Lockup in RUN -> reset with rst_cause=5'b01000 when LOCKUP_RST_EN=1; no reset when it is 0.
REQ-043 Saturation: 300 resets -> rst_count=255; fpga_rst_in low during HOLD -> immediate LOCK, mcu_nrst=0, rst_count=0.
